station_ctrl: RTL and testbench

Station-side controller for one camera: the command initiator that drives the camera's GoToStandby/StartFilming/Download/Flush inputs and consumes its status and download byte stream. It runs one capture cycle per user `start` and either downloads the frame into a bounded station store or orders a flush. Sits in the station top level beside the camera FSM, with status/data wires from the camera and command wires back to it.

---
 rtl/station_pkg.sv | 27 ++
 rtl/station_if.sv | 35 +++
 rtl/station_watchdog.sv | 42 ++++
 rtl/station_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_station_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/station_pkg.sv
// station_pkg: shared definitions for the station-side camera controller.
//   state_e        controller FSM states
//   Def*           default frame size, store capacity and watchdog limit
//   is_watched()   true for states supervised by the watchdog
package station_pkg;

  localparam int unsigned DefFrame    = 100;
  localparam int unsigned DefCapacity = 1000;
  localparam int unsigned DefTimeout  = 2047;

  typedef enum logic [2:0] {
    StIdle,
    StWake,
    StArm,
    StFilm,
    StRecv,
    StFlush,
    StFault
  } state_e;

  // Every state that waits on the camera is supervised; IDLE waits on the user
  // and FAULT is terminal.
  function automatic logic is_watched(input state_e s);
    return s inside {StWake, StArm, StFilm, StRecv, StFlush};
  endfunction

endpackage

// File: rtl/station_if.sv
// station_if: command/status wires between the station controller and the camera.
//   cam_lowpower..cam_flushing  camera state flags (cam_ready = ReadyToDownload)
//   cam_forceflush              camera force-flush request
//   cam_buffdata                download byte, valid while cam_downloading=1
//   GoToStandbyOUT..FlushOUT    commands from the station to the camera
// modport master: station side (drives commands); modport slave: camera side.
interface station_if;

  logic       cam_lowpower;
  logic       cam_standby;
  logic       cam_active;
  logic       cam_ready;
  logic       cam_downloading;
  logic       cam_flushing;
  logic       cam_forceflush;
  logic [7:0] cam_buffdata;

  logic       GoToStandbyOUT;
  logic       StartFilmingOUT;
  logic       DownloadOUT;
  logic       FlushOUT;

  modport master (
    input  cam_lowpower, cam_standby, cam_active, cam_ready, cam_downloading, cam_flushing,
    input  cam_forceflush, cam_buffdata,
    output GoToStandbyOUT, StartFilmingOUT, DownloadOUT, FlushOUT
  );

  modport slave (
    output cam_lowpower, cam_standby, cam_active, cam_ready, cam_downloading, cam_flushing,
    output cam_forceflush, cam_buffdata,
    input  GoToStandbyOUT, StartFilmingOUT, DownloadOUT, FlushOUT
  );

endinterface

// File: rtl/station_watchdog.sv
// station_watchdog: per-state cycle counter for the station controller.
//   clk, reset  system clock, synchronous active-high reset
//   clr         restart the count (asserted on every state change)
//   en          count while the controller sits in a supervised state
//   trip        the cycle now ending is the TIMEOUT-th spent in the state
module station_watchdog #(
  parameter int unsigned TIMEOUT = 2047
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic trip
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  // cnt_q holds the number of completed cycles in the state, so the cycle in
  // which it equals TIMEOUT-1 is the one that reaches TIMEOUT.
  localparam logic [CW-1:0] Limit = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign trip = en && (cnt_q == Limit);

endmodule

// File: rtl/station_ctrl.sv
// station_ctrl: station-side command initiator for one camera. Runs one capture
// cycle per user start, then either downloads the frame into a bounded store or
// orders the camera to flush it.
//   clk, reset        system clock, synchronous active-high reset
//   start, drain      user capture request / store clear (both honoured in IDLE)
//   cam               station_if.master: camera flags in, commands out
//   rx_valid, rx_byte captured download byte
//   store_count       bytes held in the station store (saturates at CAPACITY)
//   checksum          mod-256 sum of the bytes of the last/current download
//   busy, fault       not idle / watchdog tripped (sticky until reset)
//   last_flushed      last completed cycle ended in a flush
module station_ctrl
  import station_pkg::*;
#(
  parameter int unsigned FRAME    = DefFrame,
  parameter int unsigned CAPACITY = DefCapacity,
  parameter int unsigned TIMEOUT  = DefTimeout,
  localparam int unsigned W       = $clog2(CAPACITY + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           drain,
  station_if.master      cam,
  output logic           rx_valid,
  output logic [7:0]     rx_byte,
  output logic [W-1:0]   store_count,
  output logic [7:0]     checksum,
  output logic           busy,
  output logic           fault,
  output logic           last_flushed
);

  localparam logic [W:0]   FrameW = (W + 1)'(FRAME);
  localparam logic [W-1:0] CapW   = W'(CAPACITY);

  state_e state_q, state_d;

  logic         standby_cmd_q, standby_cmd_d;
  logic         film_cmd_q, film_cmd_d;
  logic         dl_cmd_q, dl_cmd_d;
  logic         flush_cmd_q, flush_cmd_d;
  logic         flush_pending_q, flush_pending_d;
  logic         last_flushed_q, last_flushed_d;
  logic         rx_valid_q, rx_valid_d;
  logic [7:0]   rx_byte_q, rx_byte_d;
  logic [W-1:0] store_count_q, store_count_d;
  logic [7:0]   checksum_q, checksum_d;

  logic         wd_trip;
  logic         state_change;
  logic [W:0]   fill_sum;
  logic         go_flush;
  logic         capture;

  // One extra bit so a nearly full store cannot wrap and look like free space.
  assign fill_sum = {1'b0, store_count_q} + FrameW;
  // A force-flush arriving in the same cycle as ReadyToDownload still counts.
  assign go_flush = flush_pending_q || cam.cam_forceflush || (fill_sum > {1'b0, CapW});
  assign capture  = (state_q == StRecv) && cam.cam_downloading;

  station_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (state_change),
    .en    (is_watched(state_q)),
    .trip  (wd_trip)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && cam.cam_lowpower) state_d = StWake;
      StWake:  if (cam.cam_standby) state_d = StArm;
      StArm:   if (cam.cam_active) state_d = StFilm;
      StFilm:  if (cam.cam_ready) state_d = go_flush ? StFlush : StRecv;
      StRecv:  if (cam.cam_lowpower) state_d = StIdle;
      StFlush: if (cam.cam_lowpower) state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
    if (wd_trip) begin
      state_d = StFault;
    end
  end

  assign state_change = (state_d != state_q);

  // Registered Moore commands: each rises with the entry edge of its state.
  // Download/Flush additionally drop once the camera acknowledges, even though
  // the state is held until the camera returns to low power.
  always_comb begin
    standby_cmd_d = (state_d == StWake);
    film_cmd_d    = (state_d == StArm);
    dl_cmd_d      = (state_d == StRecv) &&
                    ((state_q != StRecv) || (dl_cmd_q && !cam.cam_downloading));
    flush_cmd_d   = (state_d == StFlush) &&
                    ((state_q != StFlush) || (flush_cmd_q && !cam.cam_flushing));
  end

  // Capture datapath and cycle bookkeeping
  always_comb begin
    store_count_d   = store_count_q;
    checksum_d      = checksum_q;
    rx_valid_d      = 1'b0;
    rx_byte_d       = rx_byte_q;
    last_flushed_d  = last_flushed_q;
    flush_pending_d = flush_pending_q;

    if ((state_q == StIdle) && drain) begin
      store_count_d = '0;
    end

    if ((state_d == StRecv) && (state_q != StRecv)) begin
      checksum_d = '0;
    end

    if (capture) begin
      rx_valid_d = 1'b1;
      rx_byte_d  = cam.cam_buffdata;
      checksum_d = checksum_q + cam.cam_buffdata;
      // Excess bytes on a full store are still delivered, just not counted.
      if (store_count_q != CapW) begin
        store_count_d = store_count_q + W'(1);
      end
    end

    if (((state_q == StArm) || (state_q == StFilm)) && cam.cam_forceflush) begin
      flush_pending_d = 1'b1;
    end
    if ((state_d == StIdle) && (state_q != StIdle)) begin
      flush_pending_d = 1'b0;
    end

    if ((state_q == StRecv) && (state_d == StIdle)) begin
      last_flushed_d = 1'b0;
    end
    if ((state_q == StFlush) && (state_d == StIdle)) begin
      last_flushed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      standby_cmd_q   <= 1'b0;
      film_cmd_q      <= 1'b0;
      dl_cmd_q        <= 1'b0;
      flush_cmd_q     <= 1'b0;
      flush_pending_q <= 1'b0;
      last_flushed_q  <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_byte_q       <= '0;
      store_count_q   <= '0;
      checksum_q      <= '0;
    end else begin
      state_q         <= state_d;
      standby_cmd_q   <= standby_cmd_d;
      film_cmd_q      <= film_cmd_d;
      dl_cmd_q        <= dl_cmd_d;
      flush_cmd_q     <= flush_cmd_d;
      flush_pending_q <= flush_pending_d;
      last_flushed_q  <= last_flushed_d;
      rx_valid_q      <= rx_valid_d;
      rx_byte_q       <= rx_byte_d;
      store_count_q   <= store_count_d;
      checksum_q      <= checksum_d;
    end
  end

  assign cam.GoToStandbyOUT  = standby_cmd_q;
  assign cam.StartFilmingOUT = film_cmd_q;
  assign cam.DownloadOUT     = dl_cmd_q;
  assign cam.FlushOUT        = flush_cmd_q;

  assign rx_valid     = rx_valid_q;
  assign rx_byte      = rx_byte_q;
  assign store_count  = store_count_q;
  assign checksum     = checksum_q;
  assign busy         = (state_q != StIdle);
  assign fault        = (state_q == StFault);
  assign last_flushed = last_flushed_q;

endmodule

// File: tb/tb_station_ctrl.sv
// tb_station_ctrl: drives station_ctrl with a scripted camera that uses random
// delays, random gaps and random data, and checks every output against a model
// of the store (byte count, running sum, flush decision) kept in plain integers.
module tb_station_ctrl;

  localparam int unsigned FRAME    = 100;
  localparam int unsigned CAPACITY = 1000;
  localparam int unsigned TIMEOUT  = 2047;
  localparam int unsigned W        = $clog2(CAPACITY + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         drain;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic [W-1:0] store_count;
  logic [7:0]   checksum;
  logic         busy;
  logic         fault;
  logic         last_flushed;

  station_if cam_if ();

  station_ctrl #(
    .FRAME    (FRAME),
    .CAPACITY (CAPACITY),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .drain        (drain),
    .cam          (cam_if),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .store_count  (store_count),
    .checksum     (checksum),
    .busy         (busy),
    .fault        (fault),
    .last_flushed (last_flushed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_count = 0;  // model: bytes held in the station store

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cam_set(input bit lp, input bit sb, input bit ac, input bit rd,
                         input bit dl, input bit fl);
    cam_if.cam_lowpower    = lp;
    cam_if.cam_standby     = sb;
    cam_if.cam_active      = ac;
    cam_if.cam_ready       = rd;
    cam_if.cam_downloading = dl;
    cam_if.cam_flushing    = fl;
  endtask

  task automatic check_cmds(input string tag, input bit sb, input bit fm, input bit dl,
                            input bit fl);
    check_eq({tag, "_standby"}, cam_if.GoToStandbyOUT, sb);
    check_eq({tag, "_film"}, cam_if.StartFilmingOUT, fm);
    check_eq({tag, "_download"}, cam_if.DownloadOUT, dl);
    check_eq({tag, "_flush"}, cam_if.FlushOUT, fl);
  endtask

  // One full capture cycle as seen by the camera. rst_at >= 0 asserts reset
  // after that many bytes have been captured.
  task automatic run_cycle(input int nbytes, input bit ff, input bit pattern,
                           input bit do_drain, input int rst_at);
    bit         exp_flush;
    bit         lp_last;
    logic [7:0] b;
    int         sum;
    lp_last = 1'($urandom_range(0, 1));
    cam_set(1, 0, 0, 0, 0, 0);
    start = 1'b1;
    drain = do_drain;
    tick();
    start = 1'b0;
    drain = 1'b0;
    if (do_drain) m_count = 0;
    check_eq("start_count", store_count, m_count);
    check_eq("wake_busy", busy, 1);
    check_cmds("wake", 1, 0, 0, 0);
    repeat ($urandom_range(0, 3)) begin
      tick();
      check_eq("wake_hold", cam_if.GoToStandbyOUT, 1);
    end
    cam_set(0, 1, 0, 0, 0, 0);
    tick();
    check_cmds("arm", 0, 1, 0, 0);
    repeat ($urandom_range(0, 3)) tick();
    cam_set(0, 0, 1, 0, 0, 0);
    tick();
    check_cmds("film", 0, 0, 0, 0);
    repeat ($urandom_range(0, 3)) tick();
    if (ff) begin
      cam_if.cam_forceflush = 1'b1;
      tick();
      cam_if.cam_forceflush = 1'b0;
    end
    repeat ($urandom_range(0, 3)) tick();
    exp_flush = ff || (m_count + FRAME > CAPACITY);
    cam_set(0, 0, 0, 1, 0, 0);
    tick();
    check_cmds("decide", 0, 0, !exp_flush, exp_flush);
    if (exp_flush) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        check_eq("flush_hold", cam_if.FlushOUT, 1);
      end
      cam_set(0, 0, 0, 0, 0, 1);
      tick();
      check_eq("flush_drop", cam_if.FlushOUT, 0);
      repeat ($urandom_range(0, 3)) tick();
      cam_set(1, 0, 0, 0, 0, 0);
      tick();
      check_eq("flush_idle", busy, 0);
      check_eq("flush_last", last_flushed, 1);
      check_eq("flush_count", store_count, m_count);
      return;
    end
    repeat ($urandom_range(0, 2)) begin
      tick();
      check_eq("dl_hold", cam_if.DownloadOUT, 1);
    end
    sum = 0;
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_at) begin
        cam_set(1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_count = 0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_count", store_count, 0);
        check_eq("rst_sum", checksum, 0);
        check_eq("rst_download", cam_if.DownloadOUT, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        cam_set(0, 0, 0, 0, 0, 0);
        tick();
        check_eq("gap_rx_valid", rx_valid, 0);
      end
      b = pattern ? 8'(i) : 8'($urandom);
      cam_set(lp_last && (i == nbytes - 1), 0, 0, 0, 1, 0);
      cam_if.cam_buffdata = b;
      tick();
      sum += int'(b);
      if (m_count < CAPACITY) m_count++;
      check_eq("rx_valid", rx_valid, 1);
      check_eq("rx_byte", rx_byte, b);
      check_eq("dl_drop", cam_if.DownloadOUT, 0);
      check_eq("rx_count", store_count, m_count);
    end
    if (!lp_last) begin
      cam_set(1, 0, 0, 0, 0, 0);
      tick();
    end
    cam_set(1, 0, 0, 0, 0, 0);
    check_eq("dl_idle", busy, 0);
    check_eq("dl_sum", checksum, sum % 256);
    check_eq("dl_last", last_flushed, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    drain = 1'b0;
    cam_set(1, 0, 0, 0, 0, 0);
    cam_if.cam_forceflush = 1'b0;
    cam_if.cam_buffdata   = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_fault", fault, 0);
    check_eq("reset_count", store_count, 0);
    check_eq("reset_sum", checksum, 0);
    check_eq("reset_rx_valid", rx_valid, 0);
    check_eq("reset_last", last_flushed, 0);
    check_cmds("reset", 0, 0, 0, 0);

    // Bytes 0..99: 4950 mod 256 = 0x56.
    run_cycle(100, 0, 1, 0, -1);
    check_eq("pattern_count", store_count, 100);
    check_eq("pattern_sum", checksum, 8'h56);

    // Forced flush with plenty of room, then a normal cycle must download.
    run_cycle(100, 1, 0, 0, -1);
    run_cycle(100, 0, 0, 0, -1);
    check_eq("after_ff_last", last_flushed, 0);
    repeat (3) run_cycle(100, 0, 0, 0, -1);
    check_eq("pre_drain_count", store_count, 500);

    // drain and start together: store cleared and the cycle still starts.
    run_cycle(100, 0, 0, 1, -1);
    repeat (8) run_cycle(100, 0, 0, 0, -1);
    check_eq("at_900", store_count, 900);
    // 900+100 == CAPACITY downloads; 30 surplus bytes saturate the store.
    run_cycle(130, 0, 0, 0, -1);
    check_eq("full_count", store_count, CAPACITY);
    run_cycle(100, 0, 0, 0, -1);
    check_eq("full_flush_count", store_count, CAPACITY);

    // 950 + 100 > CAPACITY must flush and leave the store alone.
    run_cycle(50, 0, 0, 1, -1);
    repeat (9) run_cycle(100, 0, 0, 0, -1);
    check_eq("at_950", store_count, 950);
    run_cycle(100, 0, 0, 0, -1);
    check_eq("over_flush_last", last_flushed, 1);
    check_eq("over_count", store_count, 950);

    // Reset in the middle of a download.
    run_cycle(100, 0, 0, 1, 40);

    // Camera never leaves low power: watchdog trips in WAKE.
    cam_set(1, 0, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("wd_wake", cam_if.GoToStandbyOUT, 1);
    repeat (TIMEOUT - 2) tick();
    check_eq("wd_early", fault, 0);
    for (int n = 0; (n < 8) && (fault !== 1'b1); n++) tick();
    check_eq("wd_fault", fault, 1);
    repeat (3) tick();
    check_cmds("fault", 0, 0, 0, 0);
    check_eq("fault_busy", busy, 1);
    check_eq("fault_sticky", fault, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("fault_cleared", fault, 0);
    check_eq("fault_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
